// File: rtl/pair_seq_pkg.sv
// ============================================================================
// Module   : pair_seq_pkg
// Purpose  : Shared types, operand-pair tables and helpers for pair_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pair_seq_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_P1   = 3'd1,
    S_G1   = 3'd2,
    S_P2   = 3'd3,
    S_WAIT = 3'd4,
    S_SAMP = 3'd5,
    S_G2   = 3'd6,
    S_DONE = 3'd7
  } state_t;

  // Width of the shared wait timer (covers HOLD/GAP/LED_LAT up to 256)
  localparam int c_TMR_W = 8;

  // First operand of each pair
  localparam logic [3:0] PAIR_A [0:15] = '{
    4'hA, 4'hB, 4'h3, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0
  };

  // Second operand of each pair
  localparam logic [3:0] PAIR_B [0:15] = '{
    4'hA, 4'hA, 4'h3, 4'h2, 4'h5, 4'h0, 4'h0, 4'h0,
    4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0
  };

  // What a healthy equality checker must report for a pair
  function automatic logic expect_eq(input logic [3:0] a, input logic [3:0] b);
    return (a == b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pair_sequencer_cyc_timer.sv
// ============================================================================
// Module   : cyc_timer
// Purpose  : Loadable down-counter with zero flag; times every wait phase of
//            the pair sequencer (strobe hold, gaps, ledpin latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cyc_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  // Load on request, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/pair_sequencer.sv
// ============================================================================
// Module   : pair_sequencer
// Purpose  : Plays a fixed table of operand pairs into a 4-bit equality
//            checker (no/push1/push2), samples its ledpin after each pair,
//            tallies equal pairs and flags the first disagreeing pair.
// Options  : PAIR_SEQ_LOOP_EN - when defined, DONE restarts at pair 0 while
//            start stays high, accumulating match_cnt across passes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pair_sequencer
  import pair_seq_pkg::*;
#(
  parameter int HOLD_CYC  = 1,
  parameter int GAP_CYC   = 1,
  parameter int LED_LAT   = 2,
  parameter int NUM_PAIRS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ledpin,
  output logic [3:0] no,
  output logic       push1,
  output logic       push2,
  output logic       busy,
  output logic       done,
  output logic [4:0] match_cnt,
  output logic       err,
  output logic [3:0] err_idx
);

  // Timer reload values are "duration minus one": the phase lasts until the
  // timer reads zero, so a load of N-1 gives exactly N cycles.
  localparam logic [c_TMR_W-1:0] c_HOLD_LD = c_TMR_W'(HOLD_CYC - 1);
  localparam logic [c_TMR_W-1:0] c_GAP_LD  = c_TMR_W'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);
  localparam logic [c_TMR_W-1:0] c_LAT_LD  = c_TMR_W'(LED_LAT - 1);
  localparam logic [3:0]         c_LAST    = 4'(NUM_PAIRS - 1);
  localparam bit                 c_GAP_EN  = (GAP_CYC > 0);
  localparam logic [4:0]         c_SAT     = 5'd31;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [3:0]         r_idx;
  logic [3:0]         w_idx_nxt;
  logic [4:0]         r_match;
  logic [4:0]         w_match_nxt;
  logic               r_err;
  logic               w_err_nxt;
  logic [3:0]         r_err_idx;
  logic [3:0]         w_err_idx_nxt;
  logic [3:0]         r_no;
  logic [3:0]         w_no_nxt;
  logic               r_push1;
  logic               r_push2;
  logic               r_busy;
  logic               r_done;
  logic               w_tmr_load;
  logic [c_TMR_W-1:0] w_tmr_val;
  logic               w_tmr_zero;
  logic               w_pair_eq;

  assign w_pair_eq = expect_eq(PAIR_A[r_idx], PAIR_B[r_idx]);

  cyc_timer #(
    .WIDTH (c_TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  // Next-state, pair index, tally and timer-load decisions
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_match_nxt   = r_match;
    w_err_nxt     = r_err;
    w_err_idx_nxt = r_err_idx;
    w_tmr_load    = 1'b0;
    w_tmr_val     = c_HOLD_LD;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt   = S_P1;
          w_idx_nxt     = 4'd0;
          w_match_nxt   = 5'd0;
          w_err_nxt     = 1'b0;
          w_err_idx_nxt = 4'd0;
          w_tmr_load    = 1'b1;
          w_tmr_val     = c_HOLD_LD;
        end
      end
      S_P1: begin
        if (w_tmr_zero) begin
          w_tmr_load = 1'b1;
          if (c_GAP_EN) begin
            w_state_nxt = S_G1;
            w_tmr_val   = c_GAP_LD;
          end else begin
            w_state_nxt = S_P2;
            w_tmr_val   = c_HOLD_LD;
          end
        end
      end
      S_G1: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_P2;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_HOLD_LD;
        end
      end
      S_P2: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_WAIT;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_LAT_LD;
        end
      end
      S_WAIT: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_SAMP;
        end
      end
      S_SAMP: begin
        if (ledpin && (r_match != c_SAT)) begin
          w_match_nxt = r_match + 5'd1;
        end
        if ((ledpin != w_pair_eq) && !r_err) begin
          w_err_nxt     = 1'b1;
          w_err_idx_nxt = r_idx;
        end
        if (r_idx == c_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_idx_nxt  = r_idx + 4'd1;
          w_tmr_load = 1'b1;
          if (c_GAP_EN) begin
            w_state_nxt = S_G2;
            w_tmr_val   = c_GAP_LD;
          end else begin
            w_state_nxt = S_P1;
            w_tmr_val   = c_HOLD_LD;
          end
        end
      end
      S_G2: begin
        if (w_tmr_zero) begin
          w_state_nxt = S_P1;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_HOLD_LD;
        end
      end
      S_DONE: begin
`ifdef PAIR_SEQ_LOOP_EN
        // Keep cycling while start is held; tallies carry over between passes
        if (start) begin
          w_state_nxt = S_P1;
          w_idx_nxt   = 4'd0;
          w_tmr_load  = 1'b1;
          w_tmr_val   = c_HOLD_LD;
        end else begin
          w_state_nxt = S_IDLE;
        end
`else
        w_state_nxt = S_IDLE;
`endif
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand bus follows the state being entered so it is already valid in
  // the first strobe cycle; it simply holds outside the pair phases.
  always_comb begin
    w_no_nxt = r_no;
    case (w_state_nxt)
      S_P1, S_G1:   w_no_nxt = PAIR_A[w_idx_nxt];
      S_P2, S_WAIT: w_no_nxt = PAIR_B[w_idx_nxt];
      default:      w_no_nxt = r_no;
    endcase
  end

  // State register, pair index and result tallies
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_idx     <= 4'd0;
      r_match   <= 5'd0;
      r_err     <= 1'b0;
      r_err_idx <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_match   <= w_match_nxt;
      r_err     <= w_err_nxt;
      r_err_idx <= w_err_idx_nxt;
    end
  end

  // Registered interface outputs decoded from the state being entered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_no    <= 4'd0;
      r_push1 <= 1'b0;
      r_push2 <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_no    <= w_no_nxt;
      r_push1 <= (w_state_nxt == S_P1);
      r_push2 <= (w_state_nxt == S_P2);
      r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign no        = r_no;
  assign push1     = r_push1;
  assign push2     = r_push2;
  assign busy      = r_busy;
  assign done      = r_done;
  assign match_cnt = r_match;
  assign err       = r_err;
  assign err_idx   = r_err_idx;

endmodule

`default_nettype wire

// File: tb/tb_pair_sequencer.sv
// ============================================================================
// Module   : tb_pair_sequencer
// Purpose  : Self-checking bench for pair_sequencer. Four instances with
//            different timing/pair-count parameters share start/rst_n; each
//            has its own downstream checker model driving ledpin.
// Options  : PAIR_SEQ_LOOP_EN changes the expected behaviour at DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_pair_sequencer;

  localparam int NI = 4;
  localparam int PH [NI] = '{1, 3, 1, 2};   // HOLD_CYC
  localparam int PG [NI] = '{1, 0, 1, 2};   // GAP_CYC
  localparam int PL [NI] = '{2, 1, 2, 3};   // LED_LAT
  localparam int PN [NI] = '{5, 5, 1, 16};  // NUM_PAIRS

  localparam logic [3:0] TA [16] = '{4'hA, 4'hB, 4'h3, 4'h5, 4'h5, 4'h0, 4'h0, 4'h0,
                                     4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
  localparam logic [3:0] TB [16] = '{4'hA, 4'hA, 4'h3, 4'h2, 4'h5, 4'h0, 4'h0, 4'h0,
                                     4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};

  localparam int K_IDLE = 0, K_P1 = 1, K_G1 = 2, K_P2 = 3;
  localparam int K_WAIT = 4, K_SAMP = 5, K_G2 = 6, K_DONE = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ledpin [NI];
  logic [3:0] d_no   [NI];
  logic       d_p1   [NI];
  logic       d_p2   [NI];
  logic       d_busy [NI];
  logic       d_done [NI];
  logic [4:0] d_mc   [NI];
  logic       d_err  [NI];
  logic [3:0] d_eidx [NI];

  int n_checks = 0;
  int n_errors = 0;
  int ledmode  = 0;
  bit chk_en   = 1'b0;
  int cyc      = 0;
  int n_done     [NI];
  int first_done [NI];

  always #5 clk = ~clk;

  pair_sequencer #(.HOLD_CYC(1), .GAP_CYC(1), .LED_LAT(2), .NUM_PAIRS(5)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .ledpin(ledpin[0]), .no(d_no[0]),
    .push1(d_p1[0]), .push2(d_p2[0]), .busy(d_busy[0]), .done(d_done[0]),
    .match_cnt(d_mc[0]), .err(d_err[0]), .err_idx(d_eidx[0]));
  pair_sequencer #(.HOLD_CYC(3), .GAP_CYC(0), .LED_LAT(1), .NUM_PAIRS(5)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .ledpin(ledpin[1]), .no(d_no[1]),
    .push1(d_p1[1]), .push2(d_p2[1]), .busy(d_busy[1]), .done(d_done[1]),
    .match_cnt(d_mc[1]), .err(d_err[1]), .err_idx(d_eidx[1]));
  pair_sequencer #(.HOLD_CYC(1), .GAP_CYC(1), .LED_LAT(2), .NUM_PAIRS(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .ledpin(ledpin[2]), .no(d_no[2]),
    .push1(d_p1[2]), .push2(d_p2[2]), .busy(d_busy[2]), .done(d_done[2]),
    .match_cnt(d_mc[2]), .err(d_err[2]), .err_idx(d_eidx[2]));
  pair_sequencer #(.HOLD_CYC(2), .GAP_CYC(2), .LED_LAT(3), .NUM_PAIRS(16)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .ledpin(ledpin[3]), .no(d_no[3]),
    .push1(d_p1[3]), .push2(d_p2[3]), .busy(d_busy[3]), .done(d_done[3]),
    .match_cnt(d_mc[3]), .err(d_err[3]), .err_idx(d_eidx[3]));

  // Downstream equality checker: latch operands on strobes, report a==b a
  // cycle later; alternative modes force or randomise ledpin.
  logic [3:0] ca [NI];
  logic [3:0] cb [NI];
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        ca[i] <= 4'd0;
        cb[i] <= 4'd0;
        ledpin[i] <= 1'b0;
      end else begin
        if (d_p1[i]) ca[i] <= d_no[i];
        if (d_p2[i]) cb[i] <= d_no[i];
        case (ledmode)
          0:       ledpin[i] <= (ca[i] == cb[i]);
          1:       ledpin[i] <= 1'b0;
          2:       ledpin[i] <= 1'b1;
          default: ledpin[i] <= 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // Where in a run is cycle t (t=1 is the first strobe cycle)?  Each pair
  // occupies HOLD+GAP+HOLD+LAT+1+GAP cycles; the final pair drops its
  // trailing gap and is followed by the single DONE cycle.
  function automatic int phase_of(input int i, input int t, output int idx);
    int per, tlast, o;
    per   = 2 * PH[i] + 2 * PG[i] + PL[i] + 1;
    tlast = PN[i] * per - PG[i];
    idx   = PN[i] - 1;
    if (t > tlast) return K_DONE;
    idx = (t - 1) / per;
    o   = (t - 1) % per;
    if (o < PH[i])                       return K_P1;
    if (o < PH[i] + PG[i])               return K_G1;
    if (o < 2 * PH[i] + PG[i])           return K_P2;
    if (o < 2 * PH[i] + PG[i] + PL[i])   return K_WAIT;
    if (o == 2 * PH[i] + PG[i] + PL[i])  return K_SAMP;
    return K_G2;
  endfunction

  // Reference model: run flag, position in run, and expected tallies
  bit m_run  [NI];
  int m_t    [NI];
  int m_mc   [NI];
  bit m_err  [NI];
  int m_eidx [NI];
  always @(posedge clk) begin
    int ph, px;
    for (int i = 0; i < NI; i++) begin
      if (!rst_n) begin
        m_run[i] <= 1'b0; m_t[i] <= 0; m_mc[i] <= 0; m_err[i] <= 1'b0; m_eidx[i] <= 0;
      end else if (!m_run[i]) begin
        if (start) begin
          m_run[i] <= 1'b1; m_t[i] <= 1; m_mc[i] <= 0; m_err[i] <= 1'b0; m_eidx[i] <= 0;
        end
      end else begin
        ph = phase_of(i, m_t[i], px);
        if (ph == K_SAMP) begin
          if (ledpin[i]) m_mc[i] <= (m_mc[i] >= 31) ? 31 : m_mc[i] + 1;
          if ((ledpin[i] != (TA[px] == TB[px])) && !m_err[i]) begin
            m_err[i] <= 1'b1; m_eidx[i] <= px;
          end
        end
        if (ph == K_DONE) begin
`ifdef PAIR_SEQ_LOOP_EN
          if (start) m_t[i] <= 1;
          else begin m_run[i] <= 1'b0; m_t[i] <= 0; end
`else
          m_run[i] <= 1'b0; m_t[i] <= 0;
`endif
        end else begin
          m_t[i] <= m_t[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_inst(input int i);
    int ph, px;
    px = 0;
    ph = m_run[i] ? phase_of(i, m_t[i], px) : K_IDLE;
    chk($sformatf("u%0d push1", i), d_p1[i], (ph == K_P1));
    chk($sformatf("u%0d push2", i), d_p2[i], (ph == K_P2));
    chk($sformatf("u%0d busy", i), d_busy[i], (m_run[i] && ph != K_DONE));
    chk($sformatf("u%0d done", i), d_done[i], (ph == K_DONE));
    chk($sformatf("u%0d match_cnt", i), d_mc[i], m_mc[i]);
    chk($sformatf("u%0d err", i), d_err[i], m_err[i]);
    chk($sformatf("u%0d err_idx", i), d_eidx[i], m_eidx[i]);
    if (ph >= K_P1 && ph <= K_SAMP)
      chk($sformatf("u%0d no", i), d_no[i], (ph <= K_G1) ? TA[px] : TB[px]);
  endtask

  // One cycle: sample away from the active edge, compare, track done pulses
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (chk_en) for (int i = 0; i < NI; i++) cmp_inst(i);
    for (int i = 0; i < NI; i++) begin
      if (d_done[i]) begin
        n_done[i]++;
        if (first_done[i] == 0) first_done[i] = cyc;
      end
    end
    #1;
  endtask

  task automatic clear_done();
    cyc = 0;
    for (int i = 0; i < NI; i++) begin n_done[i] = 0; first_done[i] = 0; end
  endtask

  function automatic bit all_done();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NI; i++) if (first_done[i] == 0) r = 1'b0;
    return r;
  endfunction

  function automatic bit all_idle();
    bit r;
    r = 1'b1;
    for (int i = 0; i < NI; i++) if (d_busy[i] || d_done[i]) r = 1'b0;
    return r;
  endfunction

  task automatic run_until_done(input string nm);
    int k;
    k = 0;
    while (!all_done() && k < 400) begin tick(); k++; end
    chk({nm, " completion within budget"}, all_done(), 1);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    tick();
    while (!all_idle() && k < 400) begin tick(); k++; end
    chk({nm, " drain within budget"}, all_idle(), 1);
  endtask

  task automatic pulse_start();
    clear_done();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int k;
    clear_done();
    repeat (3) tick();
    chk_en = 1'b1;
    // Reset state
    chk("reset no", d_no[0], 0);
    chk("reset busy", d_busy[0], 0);
    chk("reset match_cnt", d_mc[0], 0);
    chk("reset err", d_err[0], 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Correct checker: run lengths and tallies
    ledmode = 0;
    pulse_start();
    run_until_done("good run");
    chk("u0 done cycle", first_done[0], 35);
    chk("u1 done cycle", first_done[1], 41);
    chk("u2 done cycle", first_done[2], 7);
    chk("u3 done cycle", first_done[3], 191);
    drain("good run");
    chk("u0 match_cnt", d_mc[0], 3);
    chk("u0 err", d_err[0], 0);
    chk("u1 match_cnt", d_mc[1], 3);
    chk("u2 match_cnt", d_mc[2], 1);
    chk("u3 match_cnt", d_mc[3], 14);
    chk("u0 done pulses", n_done[0], 1);

    // ledpin stuck low
    ledmode = 1;
    pulse_start();
    run_until_done("stuck0 run");
    drain("stuck0 run");
    chk("stuck0 u0 match_cnt", d_mc[0], 0);
    chk("stuck0 u0 err", d_err[0], 1);
    chk("stuck0 u0 err_idx", d_eidx[0], 0);
    chk("stuck0 u3 err_idx", d_eidx[3], 0);

    // Reset while u0 is in P2 of pair 2
    ledmode = 0;
    pulse_start();
    while (cyc < 17) tick();
    chk("u0 in P2 of pair 2", d_p2[0], 1);
    chk("u0 no is B[2]", d_no[0], 3);
    rst_n = 1'b0;
    tick();
    chk("mid reset push2", d_p2[0], 0);
    chk("mid reset busy", d_busy[0], 0);
    chk("mid reset no", d_no[0], 0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    run_until_done("rerun");
    chk("rerun u0 done cycle", first_done[0], 35);
    chk("rerun u0 match_cnt", d_mc[0], 3);
    drain("rerun");

    // start held high across a run
    clear_done();
    start = 1'b1;
    repeat (35) tick();
    chk("held start u0 single done", n_done[0], 1);
    chk("held start u0 match_cnt", d_mc[0], 3);
    k = 0;
    while (n_done[0] < 2 && k < 200) begin tick(); k++; end
    chk("held start second done reached", n_done[0], 2);
`ifdef PAIR_SEQ_LOOP_EN
    chk("loop second done cycle", cyc, 70);
    chk("loop match_cnt after two passes", d_mc[0], 6);
`else
    chk("rerun second done cycle", cyc, 71);
    chk("rerun match_cnt", d_mc[0], 3);
`endif
    start = 1'b0;
    drain("held start");

    // Randomised runs: checker behaviour, start length, occasional reset
    for (int r = 0; r < 10; r++) begin
      ledmode = $urandom_range(0, 3);
      clear_done();
      start = 1'b1;
      repeat ($urandom_range(1, 4)) tick();
      start = 1'b0;
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 60)) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      drain("random run");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
